stage2_inverse: RTL
===================

STAGE2_INVERSE -- requirements
Module: stage2_inverse

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 Enable  in  1  input-side enable; low blocks byte acceptance only.
REQ-004 k0, k1  in  1 each  permutation key; mode = {k1,k0}.
REQ-005 in_valid  in  1  byte-serial input strobe.
REQ-006 in_ready  out  1  high when a byte can be accepted.
REQ-007 in_data  in  8  ciphertext byte; block order a0..a3, b0..b3, c0..c3, d0..d3.
REQ-008 out_valid  out  1  restored 16-byte block is available.
REQ-009 out_ready  in  1  downstream accepts the block.
REQ-010 out_data  out  128  restored block; byte i at bits [8i+7:8i] (i=0 is a0, i=15 is d3).
REQ-011 busy  out  1  high in states LOAD and OUT.

Function
REQ-012 Block shall implement three states, IDLE, LOAD and OUT, with a 4-bit byte counter cnt.
REQ-013 in_ready shall be Enable AND (state is IDLE or LOAD); an accept is in_valid AND in_ready.
REQ-014 IDLE: on accept, latch key_r={k1,k0}, store byte 0, set cnt=1, go to LOAD.
REQ-015 LOAD: each accept stores byte cnt and increments cnt; the accept at cnt=15 goes to OUT.
REQ-016 Key inputs sampled only at byte 0; changes during LOAD or OUT shall have no effect on the current block.
REQ-017 Each byte shall be inverse-permuted at capture using key_r (byte 0 uses live {k1,k0}); out_data is fully registered.
REQ-018 Inverse maps, listed as out[7:0] sources: mode 00 {b6,b7,b4,b5,b2,b3,b0,b1}; mode 01 {b3,b2,b1,b0,b7,b6,b5,b4}; mode 10 {b0,b1,b2,b3,b4,b5,b6,b7}; mode 11 {b1,b6,b3,b4,b5,b2,b7,b0}.
REQ-019 All four maps are involutions, so inverse(forward(x))=x for every byte and mode.
REQ-020 out_valid shall assert in the cycle after the 16th accept, which gives 1-cycle latency.
REQ-021 OUT: out_valid=1 and out_data stable until out_ready=1; on that edge go to IDLE and set out_valid=0.
REQ-022 Minimum period is 17 cycles per block; there is no overlap of input and output.
REQ-023 Enable low in LOAD shall freeze cnt and stored bytes; the block resumes when Enable returns high.
REQ-024 Enable shall not affect the output handshake in OUT.
REQ-025 in_valid while in_ready=0 shall be ignored and no byte is dropped into state.

Reset
REQ-026 rst shall force immediately: state=IDLE, cnt=0, key_r=0, out_valid=0, out_data=0, busy=0.
REQ-027 Reset mid-LOAD or mid-OUT shall discard the partial or pending block; the first accept after release is byte 0.

Configuration
REQ-028 With macro STAGE2_INV_BLKCNT_EN defined: add output blk_cnt (16 bits), reset to 0, incremented on each out handshake, wrapping 0xFFFF to 0x0000.
REQ-029 Without STAGE2_INV_BLKCNT_EN: the blk_cnt port and its logic shall not exist; all other behaviour is identical.

Verification
REQ-030 Mode 00, 16 bytes of 0x80 -> out_valid one cycle after the last byte; every out byte 0x40.
REQ-031 Mode 01 with byte 0x12, mode 10 with 0x80, mode 11 with 0x80 -> out bytes 0x21, 0x01 and 0x02 respectively.
REQ-032 Key switched 00->11 after byte 0 -> all 16 bytes decoded with mode 00.
REQ-033 out_ready held low 5 cycles -> out_valid and out_data stable, in_ready=0; the next block starts only after the handshake.
REQ-034 Enable low for 3 cycles at byte 7, then rst pulsed at byte 10 -> counter frozen, then state=IDLE, out_valid=0, blk_cnt unchanged.
REQ-035 Random blocks in all modes, forward-permuted by the encrypt stage, then fed here -> original data restored; blk_cnt wraps after 65536 blocks when enabled.

Source files
------------

// File: rtl/stage2_inverse.sv
// Byte-serial inverse permutation stage: collects 16 bytes, un-permutes each with the block key.
// Optional feature: define STAGE2_INV_BLKCNT_EN to add the blk_cnt output handshake counter.
module stage2_inverse (
  input  logic         clk,
  input  logic         rst,
  input  logic         Enable,
  input  logic         k0,
  input  logic         k1,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
`ifdef STAGE2_INV_BLKCNT_EN
  ,
  output logic [15:0]  blk_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StOut} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [1:0]     key_q, key_d;
  logic [127:0]   data_q, data_d;
  logic           accept;
  logic [1:0]     mode_cur;

  // All four maps are involutions, so the same wiring serves as its own inverse.
  function automatic logic [7:0] inv_perm(input logic [1:0] mode, input logic [7:0] b);
    logic [7:0] r;
    case (mode)
      2'b00:   r = {b[6], b[7], b[4], b[5], b[2], b[3], b[0], b[1]};
      2'b01:   r = {b[3], b[2], b[1], b[0], b[7], b[6], b[5], b[4]};
      2'b10:   r = {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
      default: r = {b[1], b[6], b[3], b[4], b[5], b[2], b[7], b[0]};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      key_q   <= 2'b00;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StLoad;
      StLoad:  if (accept && (cnt_q == 4'd15)) state_d = StOut;
      StOut:   if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Byte 0 is decoded with the live key; later bytes use the key latched with it.
  always_comb begin
    mode_cur = (state_q == StIdle) ? {k1, k0} : key_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    data_d   = data_q;
    if (accept) begin
      data_d[{cnt_q, 3'b000} +: 8] = inv_perm(mode_cur, in_data);
      cnt_d                        = cnt_q + 4'd1;
      if (state_q == StIdle) key_d = {k1, k0};
    end
  end

  always_comb begin
    in_ready  = Enable && (state_q != StOut);
    accept    = in_valid && in_ready;
    out_valid = (state_q == StOut);
    busy      = (state_q != StIdle);
    out_data  = data_q;
  end

`ifdef STAGE2_INV_BLKCNT_EN
  logic [15:0] blk_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt_q <= 16'd0;
    end else if ((state_q == StOut) && out_ready) begin
      blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule
